// File: rtl/ahb_timer.sv
// AHB3-Lite machine timer: 64-bit mtime/mtimecmp with prescaler,
// zero-wait valid accesses, two-cycle ERROR on illegal ones.
module ahb_timer #(
   parameter logic       RESET_EN    = 1'b1,
   parameter logic [7:0] RESET_PRESC = 8'd0
) (
   input  logic        s_clk_i,
   input  logic        s_resetn_i,
   input  logic [4:0]  s_haddr_i,
   input  logic [31:0] s_hwdata_i,
   input  logic [2:0]  s_hburst_i,
   input  logic        s_hmastlock_i,
   input  logic [3:0]  s_hprot_i,
   input  logic [2:0]  s_hsize_i,
   input  logic [1:0]  s_htrans_i,
   input  logic        s_hwrite_i,
   input  logic        s_hsel_i,
   output logic [31:0] s_hrdata_o,
   output logic        s_hready_o,
   output logic        s_hresp_o,
   output logic        s_int_mtip_o
);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      ERR1,
      ERR2
   } state_t;

   state_t      state;
   logic        d_wr;
   logic [2:0]  d_off;

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        en;
   logic [7:0]  presc;
   logic [7:0]  cnt;
   logic [31:0] shadow;

   logic acc;
   logic bad;
   logic wr;
   logic rd;
   logic tick;

   logic unused;
   assign unused = ^{s_hburst_i, s_hmastlock_i, s_hprot_i, s_htrans_i[0]};

   assign acc = s_hsel_i & s_htrans_i[1] & s_hready_o;
   assign bad = (s_hsize_i != 3'b010)
              | (s_haddr_i[1:0] != 2'b00)
              | (s_haddr_i[4:2] > 3'd4);

   assign wr   = (state == DATA) & d_wr;
   assign rd   = (state == DATA) & ~d_wr;
   assign tick = en & (cnt == presc);

   // ERR1 stalls the bus; IDLE, DATA and ERR2 may all accept a new address
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state      <= IDLE;
         s_hready_o <= 1'b1;
         s_hresp_o  <= 1'b0;
         d_wr       <= 1'b0;
         d_off      <= 3'd0;
      end else begin
         unique case (state)
            ERR1: begin
               state      <= ERR2;
               s_hready_o <= 1'b1;
               s_hresp_o  <= 1'b1;
            end
            default: begin
               if (acc & bad) begin
                  state      <= ERR1;
                  s_hready_o <= 1'b0;
                  s_hresp_o  <= 1'b1;
               end else if (acc) begin
                  state      <= DATA;
                  s_hready_o <= 1'b1;
                  s_hresp_o  <= 1'b0;
                  d_wr       <= s_hwrite_i;
                  d_off      <= s_haddr_i[4:2];
               end else begin
                  state      <= IDLE;
                  s_hready_o <= 1'b1;
                  s_hresp_o  <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         mtime        <= 64'd0;
         mtimecmp     <= '1;
         en           <= RESET_EN;
         presc        <= RESET_PRESC;
         cnt          <= 8'd0;
         shadow       <= 32'd0;
         s_int_mtip_o <= 1'b0;
      end else begin
         s_int_mtip_o <= (mtime >= mtimecmp);

         // a bus write to either mtime half swallows that cycle's tick
         if (wr && d_off == 3'd0)
            mtime[31:0] <= s_hwdata_i;
         else if (wr && d_off == 3'd1)
            mtime[63:32] <= s_hwdata_i;
         else if (tick)
            mtime <= mtime + 64'd1;

         if (wr && d_off == 3'd2)
            mtimecmp[31:0] <= s_hwdata_i;
         if (wr && d_off == 3'd3)
            mtimecmp[63:32] <= s_hwdata_i;

         if (wr && d_off == 3'd4) begin
            en    <= s_hwdata_i[0];
            presc <= s_hwdata_i[15:8];
            cnt   <= 8'd0;
         end else if (en) begin
            cnt <= tick ? 8'd0 : cnt + 8'd1;
         end

         if (rd && d_off == 3'd0)
            shadow <= mtime[63:32];
      end
   end

   always_comb begin
      s_hrdata_o = 32'd0;
      if (rd) begin
         case (d_off)
            3'd0:    s_hrdata_o = mtime[31:0];
            3'd1:    s_hrdata_o = shadow;
            3'd2:    s_hrdata_o = mtimecmp[31:0];
            3'd3:    s_hrdata_o = mtimecmp[63:32];
            3'd4:    s_hrdata_o = {16'd0, presc, 7'd0, en};
            default: s_hrdata_o = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_timer.sv
// Bench for ahb_timer: directed scenarios with literal checks plus
// randomized bus traffic compared every cycle to a behavioural model.
module tb_ahb_timer;

   logic        clk;
   logic        rst_n;
   logic [4:0]  haddr;
   logic [31:0] hwdata;
   logic [2:0]  hburst;
   logic        hmastlock;
   logic [3:0]  hprot;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic        hwrite;
   logic        hsel;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;
   logic        mtip;

   int vectors;
   int miscompares;

   ahb_timer #(
      .RESET_EN    (1'b1),
      .RESET_PRESC (8'd0)
   ) dut (
      .s_clk_i       (clk),
      .s_resetn_i    (rst_n),
      .s_haddr_i     (haddr),
      .s_hwdata_i    (hwdata),
      .s_hburst_i    (hburst),
      .s_hmastlock_i (hmastlock),
      .s_hprot_i     (hprot),
      .s_hsize_i     (hsize),
      .s_htrans_i    (htrans),
      .s_hwrite_i    (hwrite),
      .s_hsel_i      (hsel),
      .s_hrdata_o    (hrdata),
      .s_hready_o    (hready),
      .s_hresp_o     (hresp),
      .s_int_mtip_o  (mtip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: register contents plus the data phase now in flight;
   // err_left counts remaining ERROR cycles (2 = stalled, 1 = final)
   typedef struct packed {
      logic [63:0] tm;
      logic [63:0] cmp;
      logic        en;
      logic [7:0]  presc;
      logic [7:0]  phase;
      logic [31:0] shadow;
      logic        mtip;
      logic        ph_valid;
      logic        ph_wr;
      logic [2:0]  ph_off;
      logic [1:0]  err_left;
   } model_t;

   model_t m;

   function automatic model_t reset_model();
      model_t r;
      r.tm       = 64'd0;
      r.cmp      = {64{1'b1}};
      r.en       = 1'b1;
      r.presc    = 8'd0;
      r.phase    = 8'd0;
      r.shadow   = 32'd0;
      r.mtip     = 1'b0;
      r.ph_valid = 1'b0;
      r.ph_wr    = 1'b0;
      r.ph_off   = 3'd0;
      r.err_left = 2'd0;
      return r;
   endfunction

   function automatic model_t step(
      model_t      s,
      logic        sel,
      logic [1:0]  trans,
      logic [4:0]  addr,
      logic        wrt,
      logic [2:0]  size,
      logic [31:0] wd
   );
      model_t n;
      logic   time_written;
      logic   ctrl_written;
      logic   accept;
      logic   illegal;
      int     period;
      int     ph;
      n = s;
      time_written = 1'b0;
      ctrl_written = 1'b0;
      n.mtip = (s.tm >= s.cmp);
      if (s.ph_valid && s.ph_wr) begin
         case (s.ph_off)
            3'd0: begin n.tm[31:0] = wd; time_written = 1'b1; end
            3'd1: begin n.tm[63:32] = wd; time_written = 1'b1; end
            3'd2: n.cmp[31:0] = wd;
            3'd3: n.cmp[63:32] = wd;
            3'd4: begin
               n.en = wd[0];
               n.presc = wd[15:8];
               ctrl_written = 1'b1;
            end
            default: ;
         endcase
      end
      if (s.ph_valid && !s.ph_wr && s.ph_off == 3'd0)
         n.shadow = s.tm[63:32];
      if (s.en) begin
         period = int'(s.presc) + 1;
         ph = (int'(s.phase) + 1) % period;
         n.phase = 8'(ph);
         if (ph == 0 && !time_written)
            n.tm = s.tm + 64'd1;
      end
      if (ctrl_written)
         n.phase = 8'd0;
      if (s.err_left == 2'd2) begin
         n.err_left = 2'd1;
         n.ph_valid = 1'b0;
      end else begin
         accept  = sel && trans[1];
         illegal = (size != 3'd2) || (addr[1:0] != 2'd0)
                || (addr >= 5'h14);
         n.ph_valid = accept && !illegal;
         n.err_left = (accept && illegal) ? 2'd2 : 2'd0;
         n.ph_wr    = wrt;
         n.ph_off   = addr[4:2];
      end
      return n;
   endfunction

   function automatic logic [31:0] exp_rdata(model_t s);
      if (!s.ph_valid || s.ph_wr)
         return 32'd0;
      case (s.ph_off)
         3'd0:    return s.tm[31:0];
         3'd1:    return s.shadow;
         3'd2:    return s.cmp[31:0];
         3'd3:    return s.cmp[63:32];
         3'd4:    return {16'd0, s.presc, 7'd0, s.en};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         m <= reset_model();
      else
         m <= step(m, hsel, htrans, haddr, hwrite, hsize, hwdata);
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("hready", 64'(hready), 64'(m.err_left != 2'd2));
         chk("hresp", 64'(hresp), 64'(m.err_left != 2'd0));
         chk("hrdata", 64'(hrdata), 64'(exp_rdata(m)));
         chk("mtip", 64'(mtip), 64'(m.mtip));
      end
   end

   task automatic drive(input logic act, input logic [4:0] a,
                        input logic w, input logic [2:0] sz,
                        input logic [31:0] wd);
      @(posedge clk);
      #2;
      hsel   = act;
      htrans = act ? 2'b10 : 2'b00;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      hwdata = wd;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      drive(1'b1, a, 1'b1, 3'd2, 32'd0);
      drive(1'b0, 5'd0, 1'b0, 3'd2, d);
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      drive(1'b1, a, 1'b0, 3'd2, 32'd0);
      drive(1'b0, 5'd0, 1'b0, 3'd2, 32'd0);
      @(negedge clk);
      d = hrdata;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo1;
      logic [31:0] hi1;
      logic [31:0] lo2;
      logic [31:0] hi2;
      logic        hit;
      vectors     = 0;
      miscompares = 0;
      rst_n     = 1'b0;
      hsel      = 1'b0;
      htrans    = 2'b00;
      haddr     = 5'd0;
      hwrite    = 1'b0;
      hsize     = 3'd2;
      hwdata    = 32'd0;
      hburst    = 3'd0;
      hmastlock = 1'b0;
      hprot     = 4'd0;

      #12;
      chk("rst_hready", 64'(hready), 64'd1);
      chk("rst_hresp", 64'(hresp), 64'd0);
      chk("rst_hrdata", 64'(hrdata), 64'd0);
      chk("rst_mtip", 64'(mtip), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      repeat (8) @(posedge clk);
      rd(5'h00, a);
      chk("mtime_after_10", 64'(a >= 32'd9 && a <= 32'd11), 64'd1);
      chk("mtip_idle", 64'(mtip), 64'd0);

      wr(5'h0C, 32'd0);
      wr(5'h08, 32'd50);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (m.tm == 64'd50)
            hit = 1'b1;
      end
      chk("reach_50", 64'(hit), 64'd1);
      if (hit) begin
         chk("mtip_at_50", 64'(mtip), 64'd0);
         @(negedge clk);
         chk("mtip_rise", 64'(mtip), 64'd1);
      end
      wr(5'h08, 32'hFFFF_FFFF);
      chk("mtip_hold", 64'(mtip), 64'd1);
      @(posedge clk);
      #1;
      chk("mtip_fall", 64'(mtip), 64'd0);

      wr(5'h10, 32'h0000_0301);
      rd(5'h00, a);
      repeat (37) @(posedge clk);
      rd(5'h00, b);
      chk("presc3_40cyc", 64'(b - a), 64'd10);
      wr(5'h10, 32'h0);
      rd(5'h00, a);
      repeat (17) @(posedge clk);
      rd(5'h00, b);
      chk("frozen_20cyc", 64'(b - a), 64'd0);

      wr(5'h04, 32'd0);
      drive(1'b1, 5'h00, 1'b1, 3'd2, 32'd0);
      drive(1'b1, 5'h10, 1'b1, 3'd2, 32'hFFFF_FFFE);
      drive(1'b0, 5'h00, 1'b0, 3'd2, 32'h0000_0001);
      drive(1'b1, 5'h00, 1'b0, 3'd2, 32'd0);
      drive(1'b1, 5'h04, 1'b0, 3'd2, 32'd0);
      @(negedge clk);
      lo1 = hrdata;
      drive(1'b1, 5'h00, 1'b0, 3'd2, 32'd0);
      @(negedge clk);
      hi1 = hrdata;
      drive(1'b1, 5'h04, 1'b0, 3'd2, 32'd0);
      @(negedge clk);
      lo2 = hrdata;
      drive(1'b0, 5'h00, 1'b0, 3'd2, 32'd0);
      @(negedge clk);
      hi2 = hrdata;
      chk("carry_lo1", 64'(lo1), 64'h0000_0000_FFFF_FFFF);
      chk("carry_hi1", 64'(hi1), 64'd0);
      chk("carry_lo2", 64'(lo2), 64'd1);
      chk("carry_hi2", 64'(hi2), 64'd1);

      drive(1'b1, 5'h00, 1'b0, 3'd0, 32'd0);
      drive(1'b0, 5'h00, 1'b0, 3'd2, 32'd0);
      @(negedge clk);
      chk("err1_hready", 64'(hready), 64'd0);
      chk("err1_hresp", 64'(hresp), 64'd1);
      drive(1'b1, 5'h10, 1'b0, 3'd2, 32'd0);
      @(negedge clk);
      chk("err2_hready", 64'(hready), 64'd1);
      chk("err2_hresp", 64'(hresp), 64'd1);
      drive(1'b0, 5'h00, 1'b0, 3'd2, 32'd0);
      @(negedge clk);
      chk("after_err_hresp", 64'(hresp), 64'd0);
      chk("after_err_ctrl", 64'(hrdata), 64'h1);

      drive(1'b1, 5'h14, 1'b1, 3'd2, 32'd0);
      drive(1'b0, 5'h00, 1'b0, 3'd2, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("unm_err1_hready", 64'(hready), 64'd0);
      chk("unm_err1_hresp", 64'(hresp), 64'd1);
      @(negedge clk);
      chk("unm_err2_hready", 64'(hready), 64'd1);
      chk("unm_err2_hresp", 64'(hresp), 64'd1);
      @(posedge clk);
      #1;
      rd(5'h08, a);
      chk("unm_cmp_lo", 64'(a), 64'h0000_0000_FFFF_FFFF);
      rd(5'h0C, a);
      chk("unm_cmp_hi", 64'(a), 64'd0);
      rd(5'h10, a);
      chk("unm_ctrl", 64'(a), 64'h1);

      drive(1'b1, 5'h08, 1'b1, 3'd2, 32'd0);
      drive(1'b0, 5'h00, 1'b0, 3'd2, 32'h0000_1234);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_hready", 64'(hready), 64'd1);
      chk("arst_hresp", 64'(hresp), 64'd0);
      chk("arst_hrdata", 64'(hrdata), 64'd0);
      chk("arst_mtip", 64'(mtip), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rd(5'h08, a);
      chk("arst_cmp_lo", 64'(a), 64'h0000_0000_FFFF_FFFF);
      rd(5'h0C, a);
      chk("arst_cmp_hi", 64'(a), 64'h0000_0000_FFFF_FFFF);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         hsel      = ($urandom_range(0, 7) != 0);
         htrans    = 2'($urandom_range(0, 3));
         hwrite    = 1'($urandom_range(0, 1));
         hsize     = ($urandom_range(0, 9) == 0)
                   ? 3'($urandom_range(0, 7)) : 3'd2;
         haddr     = ($urandom_range(0, 9) == 0)
                   ? 5'($urandom_range(0, 31))
                   : {3'($urandom_range(0, 7)), 2'b00};
         hburst    = 3'($urandom_range(0, 7));
         hmastlock = 1'($urandom_range(0, 1));
         hprot     = 4'($urandom_range(0, 15));
         if (haddr == 5'h10)
            hwdata = {16'd0, 8'($urandom_range(0, 3)), 7'd0,
                      1'($urandom_range(0, 3) != 0)};
         else if ($urandom_range(0, 3) == 0)
            hwdata = 32'($urandom_range(0, 3));
         else
            hwdata = $urandom;
      end
      drive(1'b0, 5'h00, 1'b0, 3'd2, 32'd0);
      repeat (4) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
